multicycle_ctrl: RTL and testbench

- Multi-cycle control FSM for the 16-bit datapath: fetches an instruction over a req/ack memory handshake, decodes opcode instr[15:12], and sequences PC, IR, ALU, register file and memory.
- Drives the sign_extend select (ext_sel) from the decoded immediate format.
- Faults to a halt state on memory timeout.
- Sits between instruction/data memory and the datapath register/ALU blocks.

---
 rtl/multicycle_ctrl_if.sv | 33 +++
 rtl/multicycle_ctrl.sv | 201 ++++++++++++++++++++
 tb/tb_multicycle_ctrl.sv | 314 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/multicycle_ctrl_if.sv
// Control/handshake bundle between the multi-cycle controller, memory and datapath.
// The controller takes the master view; memory/datapath models take the slave view.
interface multicycle_ctrl_if;
  logic        start;
  logic [15:0] instr;
  logic        mem_ack;
  logic        alu_zero;
  logic        mem_req;
  logic        mem_we;
  logic        ir_write;
  logic        pc_write;
  logic [1:0]  pc_src;
  logic [1:0]  ext_sel;
  logic [2:0]  alu_op;
  logic        alu_src_imm;
  logic        reg_write;
  logic        wb_sel;
  logic        busy;
  logic        halted;
  logic        fault;

  modport master (
    input  start, instr, mem_ack, alu_zero,
    output mem_req, mem_we, ir_write, pc_write, pc_src, ext_sel, alu_op,
           alu_src_imm, reg_write, wb_sel, busy, halted, fault
  );

  modport slave (
    output start, instr, mem_ack, alu_zero,
    input  mem_req, mem_we, ir_write, pc_write, pc_src, ext_sel, alu_op,
           alu_src_imm, reg_write, wb_sel, busy, halted, fault
  );
endinterface

// File: rtl/multicycle_ctrl.sv
// Multi-cycle control FSM for the 16-bit datapath: fetch over req/ack, decode,
// execute, memory and writeback sequencing, with a memory-timeout fault to HALT.
module multicycle_ctrl #(
  parameter int MEM_TIMEOUT = 15,
  parameter int TW          = 4
) (
  input logic             clk,
  input logic             rst,
  multicycle_ctrl_if.master bus
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_FETCH  = 3'd1;
  localparam logic [2:0] S_DECODE = 3'd2;
  localparam logic [2:0] S_EXEC   = 3'd3;
  localparam logic [2:0] S_MEM    = 3'd4;
  localparam logic [2:0] S_WB     = 3'd5;
  localparam logic [2:0] S_HALT   = 3'd6;

  localparam logic [3:0] OP_NOP  = 4'h0;
  localparam logic [3:0] OP_ADD  = 4'h1;
  localparam logic [3:0] OP_SUB  = 4'h2;
  localparam logic [3:0] OP_AND  = 4'h3;
  localparam logic [3:0] OP_OR   = 4'h4;
  localparam logic [3:0] OP_ADDI = 4'h5;
  localparam logic [3:0] OP_LW   = 4'h6;
  localparam logic [3:0] OP_SW   = 4'h7;
  localparam logic [3:0] OP_LI   = 4'h8;
  localparam logic [3:0] OP_LUI  = 4'h9;
  localparam logic [3:0] OP_BEQ  = 4'hA;
  localparam logic [3:0] OP_JMP  = 4'hB;
  localparam logic [3:0] OP_HALT = 4'hF;

  localparam logic [TW-1:0] CNT_LAST = TW'(MEM_TIMEOUT - 1);
  localparam logic [TW-1:0] CNT_MAX  = {TW{1'b1}};

  logic [2:0]    state_r;
  logic [2:0]    state_s;
  logic [TW-1:0] cnt_r;
  logic [3:0]    op_r;
  logic [1:0]    ext_sel_r;
  logic          fault_r;
  logic          timeout_s;
  logic          fault_set_s;
  logic [3:0]    dec_op_s;

  // Non-immediate opcodes keep the previous select so the extender output stays put.
  function automatic logic [1:0] ext_sel_of(input logic [3:0] op, input logic [1:0] cur);
    case (op)
      OP_ADDI, OP_LW, OP_SW: ext_sel_of = 2'b00;
      OP_LI, OP_BEQ:         ext_sel_of = 2'b01;
      OP_LUI:                ext_sel_of = 2'b11;
      OP_JMP:                ext_sel_of = 2'b10;
      default:               ext_sel_of = cur;
    endcase
  endfunction

  function automatic logic [2:0] alu_op_of(input logic [3:0] op);
    case (op)
      OP_SUB, OP_BEQ: alu_op_of = 3'b001;
      OP_AND:         alu_op_of = 3'b010;
      OP_OR:          alu_op_of = 3'b011;
      OP_LI, OP_LUI:  alu_op_of = 3'b100;
      default:        alu_op_of = 3'b000;
    endcase
  endfunction

  function automatic logic is_illegal(input logic [3:0] op);
    is_illegal = (op == 4'hC) || (op == 4'hD) || (op == 4'hE);
  endfunction

  assign dec_op_s  = bus.instr[15:12];
  assign timeout_s = (cnt_r == CNT_LAST) && !bus.mem_ack;

  // Next-state selection.
  always_comb begin
    state_s = state_r;
    case (state_r)
      S_IDLE: begin
        if (bus.start) state_s = S_FETCH;
        else           state_s = S_IDLE;
      end
      S_FETCH: begin
        if (bus.mem_ack)    state_s = S_DECODE;
        else if (timeout_s) state_s = S_HALT;
        else                state_s = S_FETCH;
      end
      S_DECODE: begin
        if (dec_op_s == OP_NOP)                             state_s = S_FETCH;
        else if (dec_op_s == OP_HALT || is_illegal(dec_op_s)) state_s = S_HALT;
        else                                                state_s = S_EXEC;
      end
      S_EXEC: begin
        case (op_r)
          OP_LW, OP_SW:   state_s = S_MEM;
          OP_BEQ, OP_JMP: state_s = S_FETCH;
          default:        state_s = S_WB;
        endcase
      end
      S_MEM: begin
        if (bus.mem_ack)    state_s = (op_r == OP_LW) ? S_WB : S_FETCH;
        else if (timeout_s) state_s = S_HALT;
        else                state_s = S_MEM;
      end
      S_WB:    state_s = S_FETCH;
      S_HALT:  state_s = S_HALT;
      default: state_s = S_IDLE;
    endcase
  end

  // Fault sources: memory timeout in a wait state, or an illegal opcode in DECODE.
  always_comb begin
    if ((state_r == S_FETCH || state_r == S_MEM) && timeout_s) fault_set_s = 1'b1;
    else if (state_r == S_DECODE && is_illegal(dec_op_s))     fault_set_s = 1'b1;
    else                                                       fault_set_s = 1'b0;
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_r <= S_IDLE;
    else     state_r <= state_s;
  end

  // Wait counter: clears on each state entry, saturates while the state holds.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                    cnt_r <= {TW{1'b0}};
    else if (state_s != state_r) cnt_r <= {TW{1'b0}};
    else if (cnt_r != CNT_MAX)  cnt_r <= cnt_r + {{(TW-1){1'b0}}, 1'b1};
    else                        cnt_r <= cnt_r;
  end

  // Opcode and extender select latched in DECODE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_r      <= 4'h0;
      ext_sel_r <= 2'b00;
    end else if (state_r == S_DECODE) begin
      op_r      <= dec_op_s;
      ext_sel_r <= ext_sel_of(dec_op_s, ext_sel_r);
    end else begin
      op_r      <= op_r;
      ext_sel_r <= ext_sel_r;
    end
  end

  // Sticky fault flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)              fault_r <= 1'b0;
    else if (fault_set_s) fault_r <= 1'b1;
    else                  fault_r <= fault_r;
  end

  // Control outputs decoded from state and latched opcode.
  always_comb begin
    bus.mem_req     = 1'b0;
    bus.mem_we      = 1'b0;
    bus.ir_write    = 1'b0;
    bus.pc_write    = 1'b0;
    bus.pc_src      = 2'b00;
    bus.alu_op      = 3'b000;
    bus.alu_src_imm = 1'b0;
    bus.reg_write   = 1'b0;
    bus.wb_sel      = 1'b0;
    bus.busy        = (state_r != S_IDLE) && (state_r != S_HALT);
    bus.halted      = (state_r == S_HALT);
    bus.ext_sel     = ext_sel_r;
    bus.fault       = fault_r;
    case (state_r)
      S_FETCH: begin
        bus.mem_req  = 1'b1;
        bus.ir_write = bus.mem_ack;
        bus.pc_write = bus.mem_ack;
      end
      S_EXEC: begin
        bus.alu_op = alu_op_of(op_r);
        case (op_r)
          OP_ADDI, OP_LW, OP_SW, OP_LI, OP_LUI: bus.alu_src_imm = 1'b1;
          OP_BEQ: begin
            bus.pc_src   = 2'b01;
            bus.pc_write = bus.alu_zero;
          end
          OP_JMP: begin
            bus.pc_src   = 2'b10;
            bus.pc_write = 1'b1;
          end
          default: bus.alu_src_imm = 1'b0;
        endcase
      end
      S_MEM: begin
        bus.mem_req = 1'b1;
        bus.mem_we  = (op_r == OP_SW);
      end
      S_WB: begin
        bus.reg_write = 1'b1;
        bus.wb_sel    = (op_r == OP_LW);
      end
      default: bus.mem_req = 1'b0;
    endcase
  end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Self-checking bench for multicycle_ctrl: random instruction streams with random
// memory wait states, checked every cycle against an instruction-level model.
module tb_multicycle_ctrl;

  localparam int TO = 15;

  typedef struct packed {
    logic       mem_req;
    logic       mem_we;
    logic       ir_write;
    logic       pc_write;
    logic [1:0] pc_src;
    logic [1:0] ext_sel;
    logic [2:0] alu_op;
    logic       alu_src_imm;
    logic       reg_write;
    logic       wb_sel;
    logic       busy;
    logic       halted;
    logic       fault;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  multicycle_ctrl_if bus ();

  multicycle_ctrl #(.MEM_TIMEOUT(TO), .TW(4)) dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_err    = 0;
  logic [1:0]  exp_ext   = 2'b00;
  logic        exp_fault = 1'b0;
  logic [15:0] cur_ins   = 16'h0000;
  logic [2:0]  cap_alu;
  logic [1:0]  cap_ext;
  logic        cap_pcw;
  int          cap_req;

  task automatic check(input string nm, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic exp_t base(input logic busy);
    exp_t e;
    e = '0;
    e.busy    = busy;
    e.ext_sel = exp_ext;
    e.fault   = exp_fault;
    return e;
  endfunction

  task automatic check_all(input exp_t e, input string tag);
    check({tag, ".mem_req"},   16'(bus.mem_req),     16'(e.mem_req));
    check({tag, ".mem_we"},    16'(bus.mem_we),      16'(e.mem_we));
    check({tag, ".ir_write"},  16'(bus.ir_write),    16'(e.ir_write));
    check({tag, ".pc_write"},  16'(bus.pc_write),    16'(e.pc_write));
    if (e.pc_write) check({tag, ".pc_src"}, 16'(bus.pc_src), 16'(e.pc_src));
    check({tag, ".ext_sel"},   16'(bus.ext_sel),     16'(e.ext_sel));
    check({tag, ".alu_op"},    16'(bus.alu_op),      16'(e.alu_op));
    check({tag, ".alu_imm"},   16'(bus.alu_src_imm), 16'(e.alu_src_imm));
    check({tag, ".reg_write"}, 16'(bus.reg_write),   16'(e.reg_write));
    check({tag, ".wb_sel"},    16'(bus.wb_sel),      16'(e.wb_sel));
    check({tag, ".busy"},      16'(bus.busy),        16'(e.busy));
    check({tag, ".halted"},    16'(bus.halted),      16'(e.halted));
    check({tag, ".fault"},     16'(bus.fault),       16'(e.fault));
  endtask

  // One clock cycle: drive inputs after the falling edge, then compare.
  task automatic step(input logic ack, input logic az, input logic st, input exp_t e, input string tag);
    @(negedge clk);
    bus.instr    = cur_ins;
    bus.mem_ack  = ack;
    bus.alu_zero = az;
    bus.start    = st;
    #2;
    check_all(e, tag);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    bus.start = 1'b0;
    bus.mem_ack = 1'b0;
    exp_ext = 2'b00;
    exp_fault = 1'b0;
    #2;
    check_all(base(1'b0), "reset");
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic start_prog();
    step(1'($urandom_range(0, 1)), 1'b0, 1'b0, base(1'b0), "idle");
    step(1'($urandom_range(0, 1)), 1'b0, 1'b1, base(1'b0), "start");
  endtask

  // Expected EXEC-cycle controls, straight from the instruction table.
  function automatic exp_t exec_exp(input logic [3:0] op, input logic az);
    exp_t e;
    e = base(1'b1);
    case (op)
      4'h1: e.alu_op = 3'b000;
      4'h2: e.alu_op = 3'b001;
      4'h3: e.alu_op = 3'b010;
      4'h4: e.alu_op = 3'b011;
      4'h5, 4'h6, 4'h7: begin e.alu_op = 3'b000; e.alu_src_imm = 1'b1; end
      4'h8, 4'h9: begin e.alu_op = 3'b100; e.alu_src_imm = 1'b1; end
      4'hA: begin e.alu_op = 3'b001; e.pc_write = az; e.pc_src = 2'b01; end
      4'hB: begin e.pc_write = 1'b1; e.pc_src = 2'b10; end
      default: e.alu_op = 3'b000;
    endcase
    return e;
  endfunction

  // Runs one instruction from FETCH. status: 0 next FETCH, 1 in HALT, 2 reset applied.
  task automatic run_instr(input logic [15:0] ins, input int fd, input int md, input logic az,
                           input int rst_at, output int ncyc, output int status);
    exp_t e;
    logic [3:0] op;
    logic ack;
    op = ins[15:12];
    cur_ins = ins;
    ncyc = 0;
    status = 0;
    cap_req = 0;
    for (int i = 0; i < TO; i++) begin
      ack = (i == fd);
      e = base(1'b1);
      e.mem_req = 1'b1;
      e.ir_write = ack;
      e.pc_write = ack;
      step(ack, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), e, "fetch");
      ncyc++;
      if (ack) break;
    end
    if (fd >= TO) begin
      exp_fault = 1'b1;
      status = 1;
      return;
    end
    step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), base(1'b1), "decode");
    ncyc++;
    if (op == 4'h0) return;
    if (op >= 4'hC) begin
      if (op != 4'hF) exp_fault = 1'b1;
      status = 1;
      return;
    end
    case (op)
      4'h5, 4'h6, 4'h7: exp_ext = 2'b00;
      4'h8, 4'hA:       exp_ext = 2'b01;
      4'h9:             exp_ext = 2'b11;
      4'hB:             exp_ext = 2'b10;
      default:          exp_ext = exp_ext;
    endcase
    step(1'($urandom_range(0, 1)), az, 1'($urandom_range(0, 1)), exec_exp(op, az), "exec");
    ncyc++;
    cap_alu = bus.alu_op;
    cap_ext = bus.ext_sel;
    cap_pcw = bus.pc_write;
    if (op == 4'hA || op == 4'hB) return;
    if (op == 4'h6 || op == 4'h7) begin
      for (int i = 0; i < TO; i++) begin
        if (i == rst_at) begin
          @(negedge clk);
          bus.mem_ack = 1'b0;
          #2;
          check("pre_rst.mem_req", 16'(bus.mem_req), 16'd1);
          rst = 1'b1;
          exp_ext = 2'b00;
          exp_fault = 1'b0;
          #1;
          check_all(base(1'b0), "rst_async");
          @(negedge clk);
          rst = 1'b0;
          status = 2;
          return;
        end
        ack = (i == md);
        e = base(1'b1);
        e.mem_req = 1'b1;
        e.mem_we = (op == 4'h7);
        step(ack, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), e, "mem");
        ncyc++;
        if (bus.mem_req) cap_req++;
        if (ack) break;
      end
      if (md >= TO) begin
        exp_fault = 1'b1;
        status = 1;
        return;
      end
      if (op == 4'h7) return;
    end
    e = base(1'b1);
    e.reg_write = 1'b1;
    e.wb_sel = (op == 4'h6);
    step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), e, "wb");
    ncyc++;
  endtask

  task automatic halt_cycles(input int n);
    exp_t e;
    for (int i = 0; i < n; i++) begin
      e = base(1'b0);
      e.halted = 1'b1;
      step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), e, "halt");
    end
  endtask

  function automatic int rand_delay();
    int r;
    r = $urandom_range(0, 99);
    if (r < 3)       return TO + 2;
    else if (r < 6)  return TO - 1;
    else if (r < 40) return $urandom_range(1, 4);
    else             return 0;
  endfunction

  initial begin
    int nc;
    int st;
    int r;
    logic [3:0] op;
    logic need_start;
    bus.start = 1'b0;
    bus.instr = 16'h0000;
    bus.mem_ack = 1'b0;
    bus.alu_zero = 1'b0;
    #12;
    check_all(base(1'b0), "reset_init");
    do_reset();
    start_prog();

    // Directed: hand-computed latencies and control values.
    run_instr(16'h1123, 0, 0, 1'b0, -1, nc, st);
    check("add.latency", 16'(nc), 16'd4);
    check("add.alu_op", 16'(cap_alu), 16'd0);
    run_instr(16'h81F0, 0, 0, 1'b0, -1, nc, st);
    check("li.ext_sel", 16'(cap_ext), 16'b01);
    check("li.alu_op", 16'(cap_alu), 16'b100);
    run_instr(16'h91F0, 0, 0, 1'b0, -1, nc, st);
    check("lui.ext_sel", 16'(cap_ext), 16'b11);
    run_instr(16'h5123, 0, 0, 1'b0, -1, nc, st);
    check("addi.ext_sel", 16'(cap_ext), 16'b00);
    run_instr(16'hB010, 0, 0, 1'b0, -1, nc, st);
    check("jmp.ext_sel", 16'(cap_ext), 16'b10);
    check("jmp.latency", 16'(nc), 16'd3);
    run_instr(16'h6214, 0, 3, 1'b0, -1, nc, st);
    check("lw.latency", 16'(nc), 16'd8);
    check("lw.req_cycles", 16'(cap_req), 16'd4);
    run_instr(16'h7214, 0, 0, 1'b0, -1, nc, st);
    check("sw.latency", 16'(nc), 16'd4);
    run_instr(16'hA105, 0, 0, 1'b1, -1, nc, st);
    check("beq_taken.pc_write", 16'(cap_pcw), 16'd1);
    run_instr(16'hA105, 0, 0, 1'b0, -1, nc, st);
    check("beq_not.pc_write", 16'(cap_pcw), 16'd0);
    run_instr(16'h0000, 0, 0, 1'b0, -1, nc, st);
    check("nop.latency", 16'(nc), 16'd2);
    run_instr(16'h1123, TO - 1, 0, 1'b0, -1, nc, st);
    check("late_ack.status", 16'(st), 16'd0);
    check("late_ack.fault", 16'(bus.fault), 16'd0);
    run_instr(16'h1123, TO + 5, 0, 1'b0, -1, nc, st);
    check("timeout.cycles", 16'(nc), 16'd15);
    halt_cycles(2);
    check("timeout.fault", 16'(bus.fault), 16'd1);
    do_reset();
    start_prog();
    run_instr(16'h6214, 0, 8, 1'b0, 2, nc, st);
    check("mid_mem_rst.status", 16'(st), 16'd2);
    start_prog();
    run_instr(16'hF000, 0, 0, 1'b0, -1, nc, st);
    halt_cycles(2);
    check("halt_op.fault", 16'(bus.fault), 16'd0);
    do_reset();
    start_prog();
    run_instr(16'hC000, 0, 0, 1'b0, -1, nc, st);
    halt_cycles(2);
    check("illegal.fault", 16'(bus.fault), 16'd1);
    do_reset();

    // Random instruction stream.
    need_start = 1'b1;
    for (int k = 0; k < 300; k++) begin
      if (need_start) begin
        start_prog();
        need_start = 1'b0;
      end
      r = $urandom_range(0, 99);
      if (r < 3)      op = 4'hF;
      else if (r < 6) op = 4'(12 + $urandom_range(0, 2));
      else            op = 4'($urandom_range(0, 11));
      run_instr({op, 12'($urandom_range(0, 4095))}, rand_delay(), rand_delay(),
                1'($urandom_range(0, 1)), ($urandom_range(0, 99) < 4) ? 0 : -1, nc, st);
      if (st == 1) begin
        halt_cycles($urandom_range(1, 3));
        do_reset();
        need_start = 1'b1;
      end else if (st == 2) begin
        need_start = 1'b1;
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
